// File: rtl/trace_checker_if.sv
// Bundle of the golden-trace loader handshake, the retire-event stream and the
// checker results. The bench (or loader) drives the master side, the checker
// sits on the slave side.
interface trace_checker_if #(
  parameter int CNT_W = 16
);
  logic             exp_valid;
  logic             exp_ready;
  logic [1:0]       exp_type;
  logic [2:0]       exp_id;
  logic [15:0]      exp_addr;
  logic [15:0]      exp_value;
  logic             reg_write;
  logic [2:0]       write_reg;
  logic [15:0]      write_data;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_data_in;
  logic [15:0]      mem_data_out;
  logic             halt;
  logic             pass;
  logic             fail;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] err_index;
  logic [CNT_W-1:0] match_count;

  modport master (
    output exp_valid, exp_type, exp_id, exp_addr, exp_value,
    output reg_write, write_reg, write_data, mem_read, mem_write,
    output mem_addr, mem_data_in, mem_data_out, halt,
    input  exp_ready, pass, fail, err_code, err_index, match_count
  );

  modport slave (
    input  exp_valid, exp_type, exp_id, exp_addr, exp_value,
    input  reg_write, write_reg, write_data, mem_read, mem_write,
    input  mem_addr, mem_data_in, mem_data_out, halt,
    output exp_ready, pass, fail, err_code, err_index, match_count
  );
endinterface

// File: rtl/trace_checker.sv
// Commit-trace checker: buffers golden entries in a FIFO and compares up to
// four retire events per cycle (REG, LOAD, STORE, HALT in that slot order)
// against consecutive FIFO entries. The first divergence is latched sticky.
module trace_checker #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  trace_checker_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {S_RUN, S_DONE, S_FAIL} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CW-1:0]    r_count;
  logic [CNT_W-1:0] r_match_count;
  logic [2:0]       r_err_code;
  logic [CNT_W-1:0] r_err_index;

  logic [1:0]       r_type  [DEPTH];
  logic [2:0]       r_id    [DEPTH];
  logic [15:0]      r_addr  [DEPTH];
  logic [15:0]      r_value [DEPTH];

  logic             w_run;
  logic             w_exp_ready;
  logic [3:0]       w_ev;
  logic [2:0]       w_n;
  logic [PTR_W-1:0] w_slot;
  logic [2:0]       w_code;
  logic             w_err;
  logic [2:0]       w_err_code;
  logic [2:0]       w_err_k;
  logic [CW-1:0]    w_rem;
  logic             w_left;
  logic             w_push;
  logic [CNT_W:0]   w_mc_sum;

  assign w_run       = (r_state == S_RUN);
  assign w_exp_ready = w_run && (r_count < CW'(DEPTH));

  // Slot assignment and per-slot compare; the lowest failing slot wins
  always_comb begin
    w_ev       = w_run ? {bus.halt, bus.mem_write, bus.mem_read, bus.reg_write} : 4'b0000;
    w_n        = 3'd0;
    w_slot     = r_head;
    w_code     = 3'd0;
    w_err      = 1'b0;
    w_err_code = 3'd0;
    w_err_k    = 3'd0;
    for (int e = 0; e < 4; e++) begin
      if (w_ev[e]) begin
        w_slot = r_head + PTR_W'(w_n);
        w_code = 3'd0;
        if (r_count <= CW'(w_n)) begin
          w_code = 3'd1;
        end else if (r_type[w_slot] != 2'(e)) begin
          w_code = 3'd2;
        end else if (e == 0) begin
          if (r_id[w_slot] != bus.write_reg)          w_code = 3'd3;
          else if (r_value[w_slot] != bus.write_data) w_code = 3'd4;
        end else if (e == 1) begin
          if (r_addr[w_slot] != bus.mem_addr)           w_code = 3'd3;
          else if (r_value[w_slot] != bus.mem_data_out) w_code = 3'd4;
        end else if (e == 2) begin
          if (r_addr[w_slot] != bus.mem_addr)          w_code = 3'd3;
          else if (r_value[w_slot] != bus.mem_data_in) w_code = 3'd4;
        end
        if (!w_err && (w_code != 3'd0)) begin
          w_err      = 1'b1;
          w_err_code = w_code;
          w_err_k    = w_n;
        end
        w_n = w_n + 3'd1;
      end
    end
    w_rem    = r_count - CW'(w_n);
    w_left   = !w_err && w_ev[3] && (w_rem != '0);
    // A push in the HALT cycle is dropped: the run ends there either way.
    w_push   = bus.exp_valid && w_exp_ready && !w_err && !w_ev[3];
    w_mc_sum = {1'b0, r_match_count} + (CNT_W+1)'(w_n);
  end

  // Next-state selection: any divergence is terminal, a clean HALT finishes
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_RUN: begin
        if (w_err || w_left) w_state_next = S_FAIL;
        else if (w_ev[3])    w_state_next = S_DONE;
      end
      default: w_state_next = r_state;
    endcase
  end

  // Control state: FSM, FIFO pointers, match counter and latched error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_match_count <= '0;
      r_err_code    <= 3'd0;
      r_err_index   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_run) begin
        if (w_err) begin
          r_err_code  <= w_err_code;
          r_err_index <= r_match_count + CNT_W'(w_err_k);
        end else if (w_left) begin
          r_err_code  <= 3'd5;
          r_err_index <= r_match_count + CNT_W'(w_n);
        end else begin
          r_head        <= r_head + PTR_W'(w_n);
          r_tail        <= r_tail + PTR_W'(w_push);
          r_count       <= r_count - CW'(w_n) + CW'(w_push);
          r_match_count <= w_mc_sum[CNT_W] ? {CNT_W{1'b1}} : w_mc_sum[CNT_W-1:0];
        end
      end
    end
  end

  // FIFO storage is pure data and needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_type[r_tail]  <= bus.exp_type;
      r_id[r_tail]    <= bus.exp_id;
      r_addr[r_tail]  <= bus.exp_addr;
      r_value[r_tail] <= bus.exp_value;
    end
  end

  assign bus.exp_ready   = w_exp_ready;
  assign bus.pass        = (r_state == S_DONE);
  assign bus.fail        = (r_state == S_FAIL);
  assign bus.err_code    = r_err_code;
  assign bus.err_index   = r_err_index;
  assign bus.match_count = r_match_count;
endmodule

// File: doc/trace_checker.md
Name: trace_checker

Overview:
Synthesizable commit-trace checker that consumes a golden trace and compares it against the processor's retire stream. The retire stream is REG writes, LOADs, STOREs and HALT, taken from the same qualified WB/MEM signals the bench logs.
A loader pushes expected entries through a valid/ready port into an internal FIFO. Each cycle the block pops one entry per retired event and compares it against that event. The first divergence is latched as a sticky pass/fail result for regression sign-off.

Parameters:
DEPTH, 16, expected-entry FIFO depth; power of 2, minimum 4
CNT_W, 16, width of match_count and err_index

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
exp_valid  in  1  expected entry valid
exp_ready  out  1  FIFO can accept entry
exp_type  in  2  0=REG 1=LOAD 2=STORE 3=HALT
exp_id  in  3  expected register number (REG only)
exp_addr  in  16  expected memory address (LOAD/STORE)
exp_value  in  16  expected data
reg_write  in  1  qualified register-write retire event
write_reg  in  3  register written
write_data  in  16  register write data
mem_read  in  1  qualified load event
mem_write  in  1  qualified store event
mem_addr  in  16  memory address
mem_data_in  in  16  store data
mem_data_out  in  16  load data
halt  in  1  halt reached WB
pass  out  1  HALT matched with FIFO empty (sticky)
fail  out  1  mismatch detected (sticky)
err_code  out  3  0 none, 1 underflow, 2 type, 3 id/addr, 4 value, 5 leftover at halt
err_index  out  CNT_W  ordinal of the failing event
match_count  out  CNT_W  events matched so far, saturating

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. Reset empties the FIFO and enters RUN. Reset values: pass=0, fail=0, err_code=0, err_index=0, match_count=0. exp_ready reflects RUN with an empty FIFO, so it reads 1 during reset.
- States:
  - RUN: FIFO accepts entries and events are checked.
  - DONE: pass=1.
  - FAIL: fail=1.
  - DONE and FAIL are absorbing until rst. In both, exp_ready=0 and all events are ignored.
- exp_ready = RUN and (count < DEPTH). A push occurs when exp_valid and exp_ready are both 1.
- Events per cycle: ordered REG, LOAD, STORE, HALT. Each event with its input high occupies the next slot, so there are 0 to 4 slots per cycle.
  - Slot k compares against FIFO entry head+k.
  - Only entries resident at the rising edge are visible. An entry pushed in the same cycle cannot satisfy an event.
- Compare rules:
  - REG: exp_id==write_reg and exp_value==write_data.
  - LOAD: exp_addr==mem_addr and exp_value==mem_data_out.
  - STORE: exp_addr==mem_addr and exp_value==mem_data_in.
  - HALT: type check only.
- Per-slot error priority: underflow (slot k with count<=k) > type mismatch > id/addr mismatch > value mismatch.
  - Across slots, the lowest slot index wins.
  - err_index = match_count + k, using the pre-update match_count.
- Clean cycle with n events:
  - Pop n entries; count_next = count - n + push.
  - match_count increments by n and saturates at 2^CNT_W-1.
  - Head and tail pointers wrap modulo DEPTH.
- Failing cycle: go to FAIL and latch err_code and err_index. No pops occur and match_count is frozen.
- HALT slot matched cleanly:
  - Go to DONE if count - n == 0, with any same-cycle push ignored.
  - Otherwise go to FAIL with err_code=5 and err_index = match_count + n.
- mem_read and mem_write high together are checked as two slots (LOAD, then STORE). No special casing.
- Outputs are registered, and results are visible the cycle after the event edge.
- FIFO is full when count==DEPTH, which drives exp_ready=0. Pops and a push in the same full cycle are legal only when exp_ready was 1.

Test Plan:
- Load REG(id 3, 0x1234) then HALT; drive reg_write, write_reg=3, write_data=0x1234; next cycle halt -> match_count=2, pass=1, fail=0, err_code=0.
- Load REG(1, 0x00AA) then LOAD(0x0040, 0xBEEF); drive reg_write and mem_read in the same cycle with matching data -> both popped in one cycle, match_count=2, count=0, no fail.
- Load STORE(0x0010, 0x5555); drive mem_write, mem_addr=0x0010, mem_data_in=0x5556 -> fail=1, err_code=4, err_index=0; a later matching event leaves match_count=0.
- FIFO empty and reg_write pulsed, with exp_valid asserted the same cycle -> fail=1, err_code=1, err_index=0, exp_ready=0 afterwards.
- Push DEPTH entries -> exp_ready drops to 0 after the DEPTH-th accept; retire DEPTH+4 matching REG events while streaming entries through the wrapped pointers -> match_count=DEPTH+4, no fail.
- Load REG, REG, HALT, REG; retire REG, REG, HALT -> fail=1, err_code=5, err_index=3. Assert rst mid-run -> all outputs 0 and exp_ready=1 asynchronously.
